// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - state/port encodings and round-robin pick for ram_arbiter
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // A port just granted is masked so a request still held through its grant
  // cycle is not served twice.
  function automatic state_e next_state(input logic a_req, input logic b_req,
                                        input state_e cur, input port_e last);
    logic a_p;
    logic b_p;
    state_e nxt;
    a_p = a_req && (cur != ST_GNT_A);
    b_p = b_req && (cur != ST_GNT_B);
    nxt = ST_IDLE;
    if (a_p && b_p) begin
      nxt = (last == PORT_A) ? ST_GNT_B : ST_GNT_A;
    end else if (a_p) begin
      nxt = ST_GNT_A;
    end else if (b_p) begin
      nxt = ST_GNT_B;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port front end for a single-port async-read RAM
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic         a_we,
  input  logic [M-1:0] a_addr,
  input  logic [N-1:0] a_wdata,
  output logic         a_gnt,
  output logic [N-1:0] a_rdata,
  output logic         a_rvalid,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [M-1:0] b_addr,
  input  logic [N-1:0] b_wdata,
  output logic         b_gnt,
  output logic [N-1:0] b_rdata,
  output logic         b_rvalid,
  output logic [M-1:0] ram_addr,
  output logic [N-1:0] ram_datain,
  output logic         ram_we,
  input  logic [N-1:0] ram_dataout
);

  state_e       state_q, state_d;
  port_e        last_q, last_d;
  logic [N-1:0] a_rdata_q, b_rdata_q;
  logic         a_rvalid_q, b_rvalid_q;

  always_comb begin
    state_d = next_state(a_req, b_req, state_q, last_q);
    case (state_q)
      ST_GNT_A: last_d = PORT_A;
      ST_GNT_B: last_d = PORT_B;
      default:  last_d = last_q;
    endcase
  end

  always_comb begin
    ram_addr   = '0;
    ram_datain = '0;
    ram_we     = 1'b0;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    case (state_q)
      ST_GNT_A: begin
        ram_addr   = a_addr;
        ram_datain = a_wdata;
        ram_we     = a_we & ~rst;
        a_gnt      = 1'b1;
      end
      ST_GNT_B: begin
        ram_addr   = b_addr;
        ram_datain = b_wdata;
        ram_we     = b_we & ~rst;
        b_gnt      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= PORT_B;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      a_rvalid_q <= (state_q == ST_GNT_A) && !a_we;
      b_rvalid_q <= (state_q == ST_GNT_B) && !b_we;
      // Read data is captured only for reads; writes leave it untouched.
      if ((state_q == ST_GNT_A) && !a_we) a_rdata_q <= ram_dataout;
      if ((state_q == ST_GNT_B) && !b_we) b_rdata_q <= ram_dataout;
    end
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed vector table plus randomized model check for ram_arbiter
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] ram_addr, ram_datain, ram_dataout;
  logic       ram_we;

  int n_cmp = 0;
  int n_fail = 0;

  ram_arbiter #(.N(8), .M(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_we(ram_we),
    .ram_dataout(ram_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // RAM behind the arbiter: async read, sync write
  logic [7:0] mem [256];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_datain;
    end
  end
  assign ram_dataout = mem[ram_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       ar, aw;
    logic [7:0] aa, ad;
    logic       br, bw;
    logic [7:0] ba, bd;
    logic [1:0] eg;
    logic       ewe;
    logic       earv;
    logic [7:0] eard;
    logic       ebrv;
    logic [7:0] ebrd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic ar, input logic aw,
                              input logic [7:0] aa, input logic [7:0] ad,
                              input logic br, input logic bw,
                              input logic [7:0] ba, input logic [7:0] bd,
                              input logic [1:0] eg, input logic ewe,
                              input logic earv, input logic [7:0] eard,
                              input logic ebrv, input logic [7:0] ebrd);
    vec_t v;
    v.rst = r; v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.eg = eg; v.ewe = ewe; v.earv = earv; v.eard = eard;
    v.ebrv = ebrv; v.ebrd = ebrd;
    return v;
  endfunction

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; idle_inputs();
    @(posedge clk); #1;
    mem_init = 0;
  endtask

  vec_t vecs[$];

  // randomized-phase reference state
  logic [7:0] shadow [256];
  logic       exp_ag, exp_bg, seen_ag, seen_bg;
  logic       m_arv, m_brv;
  logic [7:0] m_ard, m_brd;
  int         m_last;
  logic       e_we;
  logic [7:0] e_addr, e_din;
  logic       elig_a, elig_b;

  initial begin
    rst = 1; mem_init = 1; idle_inputs();

    //          rst ar aw aa     ad     br bw ba     bd      g     we  arv ard    brv brd
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 2'b10,1, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 2'b10,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 1,8'hA5, 0,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'hA5, 0,8'h00));
    vecs.push_back(mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'hA5, 0,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 1,0,8'h00,8'h00, 1,0,8'h01,8'h00, 2'b00,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 1,0,8'h00,8'h00, 1,0,8'h01,8'h00, 2'b10,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,0,8'h01,8'h00, 2'b01,0, 1,8'h03, 0,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h03, 1,8'h0A));
    vecs.push_back(mk(0, 1,0,8'h02,8'h00, 1,0,8'h03,8'h00, 2'b00,0, 0,8'h03, 0,8'h0A));
    vecs.push_back(mk(0, 1,0,8'h02,8'h00, 1,0,8'h03,8'h00, 2'b10,0, 0,8'h03, 0,8'h0A));
    vecs.push_back(mk(0, 1,0,8'h02,8'h00, 1,0,8'h03,8'h00, 2'b01,0, 1,8'h11, 0,8'h0A));
    vecs.push_back(mk(0, 1,0,8'h02,8'h00, 1,0,8'h03,8'h00, 2'b10,0, 0,8'h11, 1,8'h18));
    vecs.push_back(mk(0, 1,0,8'h02,8'h00, 1,0,8'h03,8'h00, 2'b01,0, 1,8'h11, 0,8'h18));
    vecs.push_back(mk(0, 1,0,8'h02,8'h00, 1,0,8'h03,8'h00, 2'b10,0, 0,8'h11, 1,8'h18));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,0,8'h03,8'h00, 2'b01,0, 1,8'h11, 0,8'h18));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h11, 1,8'h18));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 1,1,8'h20,8'h3C, 2'b00,0, 0,8'h11, 0,8'h18));
    vecs.push_back(mk(0, 1,0,8'h20,8'h00, 1,1,8'h20,8'h3C, 2'b01,1, 0,8'h11, 0,8'h18));
    vecs.push_back(mk(0, 1,0,8'h20,8'h00, 0,0,8'h00,8'h00, 2'b10,0, 0,8'h11, 0,8'h18));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 1,8'h3C, 0,8'h18));
    vecs.push_back(mk(0, 1,1,8'h30,8'hFF, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h3C, 0,8'h18));
    vecs.push_back(mk(1, 1,1,8'h30,8'hFF, 0,0,8'h00,8'h00, 2'b10,0, 0,8'h3C, 0,8'h18));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h00, 0,8'h00));
    vecs.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 2'b00,0, 0,8'h00, 0,8'h00));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      a_req = vecs[i].ar; a_we = vecs[i].aw; a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
      b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {a_gnt, b_gnt, ram_we, a_rvalid, a_rdata, b_rvalid, b_rdata},
            {vecs[i].eg, vecs[i].ewe, vecs[i].earv, vecs[i].eard, vecs[i].ebrv, vecs[i].ebrd});
    end

    check("ram_10_written", mem[8'h10], 8'hA5);
    check("ram_20_written", mem[8'h20], 8'h3C);
    check("ram_30_reset_blocked", mem[8'h30], pat(8'h30));

    // randomized traffic against a transaction-level model
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    shadow[8'h10] = 8'hA5;
    shadow[8'h20] = 8'h3C;
    do_reset();
    rst = 0;
    exp_ag = 0; exp_bg = 0; seen_ag = 0; seen_bg = 0;
    m_arv = 0; m_brv = 0; m_ard = 0; m_brd = 0; m_last = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!a_req || seen_ag) begin
        if ($urandom_range(0, 2) != 0) begin
          a_req = 1; a_we = 1'($urandom_range(0, 1));
          a_addr = 8'($urandom_range(0, 15)); a_wdata = 8'($urandom);
        end else a_req = 0;
      end
      if (!b_req || seen_bg) begin
        if ($urandom_range(0, 2) != 0) begin
          b_req = 1; b_we = 1'($urandom_range(0, 1));
          b_addr = 8'($urandom_range(0, 15)); b_wdata = 8'($urandom);
        end else b_req = 0;
      end
      @(negedge clk);
      e_we = 0; e_addr = 0; e_din = 0;
      if (exp_ag) begin e_we = a_we; e_addr = a_addr; e_din = a_wdata; end
      if (exp_bg) begin e_we = b_we; e_addr = b_addr; e_din = b_wdata; end
      check($sformatf("rnd_bus%0d", c),
            {a_gnt, b_gnt, ram_we, ram_addr, ram_datain},
            {exp_ag, exp_bg, e_we, e_addr, e_din});
      check($sformatf("rnd_rd%0d", c),
            {a_rvalid, a_rdata, b_rvalid, b_rdata},
            {m_arv, m_ard, m_brv, m_brd});

      m_arv = 0; m_brv = 0;
      if (exp_ag) begin
        if (a_we) shadow[a_addr] = a_wdata;
        else begin m_ard = shadow[a_addr]; m_arv = 1; end
        m_last = 0;
      end
      if (exp_bg) begin
        if (b_we) shadow[b_addr] = b_wdata;
        else begin m_brd = shadow[b_addr]; m_brv = 1; end
        m_last = 1;
      end
      elig_a = a_req && !exp_ag;
      elig_b = b_req && !exp_bg;
      if (elig_a && elig_b) begin
        exp_ag = (m_last == 1);
        exp_bg = (m_last == 0);
      end else begin
        exp_ag = elig_a;
        exp_bg = elig_b;
      end
      seen_ag = a_gnt;
      seen_bg = b_gnt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
